// File: rtl/instruction_fetch_if.sv
// Instruction-memory request/response bus for instruction_fetch.
// master = fetch unit, slave = instruction memory.
interface instruction_fetch_if;
  logic        imemReqValid;
  logic        imemReqReady;
  logic [63:0] imemReqAddr;
  logic        imemRspValid;
  logic [31:0] imemRspData;

  modport master (
    output imemReqValid,
    output imemReqAddr,
    input  imemReqReady,
    input  imemRspValid,
    input  imemRspData
  );

  modport slave (
    input  imemReqValid,
    input  imemReqAddr,
    output imemReqReady,
    output imemRspValid,
    output imemRspData
  );
endinterface

// File: rtl/instruction_fetch.sv
// Instruction fetch: in-order imem requests, tagged response FIFO,
// redirect drain. Optional HLT stop enabled by macro FETCH_HALT_EN.
module instruction_fetch #(
  parameter logic [63:0] RESET_PC   = 64'h0,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic                clock,
  input  logic                reset,
  instruction_fetch_if.master imem,
  output logic [31:0]         instruction,
  output logic [63:0]         instrPC,
  output logic                instrValid,
  input  logic                instrReady,
  input  logic                redirect,
  input  logic [63:0]         redirectTarget,
  output logic                halted
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW:0] DEPTH_C = (PW+1)'(FIFO_DEPTH);
  localparam logic [63:0] PC_INIT = RESET_PC & ~64'h3;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] word;
  } fq_t;

`ifdef FETCH_HALT_EN
  localparam logic [31:0] HLT = 32'hD4400000;
  typedef enum logic [1:0] {
    IDLE, FETCH, DRAIN, HALT
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE, FETCH, DRAIN
  } state_t;
`endif

  state_t state;
  state_t state_nx;

  logic [63:0] fetch_pc;
  logic [63:0] target;

  fq_t         fq [FIFO_DEPTH];
  logic [63:0] tq [FIFO_DEPTH];

  logic [PW-1:0] wp;
  logic [PW-1:0] rp;
  logic [AW-1:0] twp;
  logic [AW-1:0] trp;

  logic [PW-1:0] inflight;
  logic [PW-1:0] inflight_nx;
  logic [PW-1:0] discard;
  logic [PW-1:0] discard_nx;
  logic [PW-1:0] count;
  logic [PW:0]   occ;

  logic req_fire;
  logic rsp_acc;
  logic pop;
  logic redir;
  logic fq_wr;
  logic empty;
  logic hlt_pop;
  fq_t  head;

  assign target = redirectTarget & ~64'h3;

  assign count = wp - rp;
  assign empty = (wp == rp);
  assign occ   = {1'b0, count} + {1'b0, inflight};
  assign head  = fq[rp[AW-1:0]];

  assign imem.imemReqValid = (state == FETCH) &&
                             (occ < DEPTH_C);
  assign imem.imemReqAddr  = fetch_pc;

  assign req_fire = imem.imemReqValid & imem.imemReqReady;
  assign rsp_acc  = imem.imemRspValid & (inflight != '0);

  assign instrValid  = ~empty & (state == FETCH);
  assign instruction = instrValid ? head.word : '0;
  assign instrPC     = instrValid ? head.pc   : '0;
  assign pop         = instrValid & instrReady;

  assign redir = redirect &
                 ((state == FETCH) | (state == DRAIN));

  assign fq_wr = rsp_acc & (state == FETCH) &
                 ~redir & (discard == '0);

  assign inflight_nx = inflight + PW'(req_fire) -
                       PW'(rsp_acc);

`ifdef FETCH_HALT_EN
  assign hlt_pop = pop & (head.word == HLT);
  assign halted  = (state == HALT);
`else
  assign hlt_pop = 1'b0;
  assign halted  = 1'b0;
`endif

  // Stale-response count: reload on redirect, tick down per drop.
  always_comb begin
    discard_nx = discard;
    if (redir)
      discard_nx = inflight_nx;
    else if (rsp_acc && discard != '0)
      discard_nx = discard - PW'(1);
  end

  // Next-state decode for the fetch FSM.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:
        state_nx = FETCH;
      FETCH: begin
        if (hlt_pop)
          state_nx = state_t'(2'd3);
        else if (redir && inflight_nx != '0)
          state_nx = DRAIN;
      end
      DRAIN: begin
        if (discard_nx == '0)
          state_nx = FETCH;
      end
`ifdef FETCH_HALT_EN
      HALT:
        state_nx = HALT;
`endif
      default:
        state_nx = IDLE;
    endcase
  end

  // FSM, fetch PC, FIFO/tag pointers and counters.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      fetch_pc <= PC_INIT;
      wp       <= '0;
      rp       <= '0;
      twp      <= '0;
      trp      <= '0;
      inflight <= '0;
      discard  <= '0;
    end else begin
      state    <= state_nx;
      inflight <= inflight_nx;
      discard  <= discard_nx;
      if (req_fire)
        twp <= twp + AW'(1);
      if (rsp_acc)
        trp <= trp + AW'(1);
      if (redir) begin
        fetch_pc <= target;
        wp       <= '0;
        rp       <= '0;
      end else begin
        if (req_fire)
          fetch_pc <= fetch_pc + 64'd4;
        if (fq_wr)
          wp <= wp + PW'(1);
        if (pop)
          rp <= rp + PW'(1);
      end
    end
  end

  // Tag queue and fetch buffer storage.
  always_ff @(posedge clock) begin
    if (req_fire)
      tq[twp] <= fetch_pc;
    if (fq_wr)
      fq[wp[AW-1:0]] <= '{pc:   tq[trp],
                          word: imem.imemRspData};
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch with a latency-configurable
// in-order memory model; HLT checks follow FETCH_HALT_EN.
module tb_instruction_fetch;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        instrReady;
  logic        redirect;
  logic [63:0] redirectTarget;
  logic [31:0] instruction;
  logic [63:0] instrPC;
  logic        instrValid;
  logic        halted;

  instruction_fetch_if bus();

  instruction_fetch #(
    .RESET_PC   (64'h100),
    .FIFO_DEPTH (4)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .imem           (bus),
    .instruction    (instruction),
    .instrPC        (instrPC),
    .instrValid     (instrValid),
    .instrReady     (instrReady),
    .redirect       (redirect),
    .redirectTarget (redirectTarget),
    .halted         (halted)
  );

  always #5 clock = ~clock;

  int         total = 0;
  int         bad   = 0;
  int         cyc   = 0;
  int         lat   = 1;
  int         nreq  = 0;
  logic [7:0] gen   = 8'd0;
  bit         hlt_on = 1'b0;

  logic [63:0] pend_a [$];
  logic [31:0] pend_w [$];
  int          pend_due [$];
  logic [63:0] got_pc [$];
  logic [31:0] got_w [$];
  int          got_cyc [$];
  logic [63:0] req_log [$];

  function automatic logic [31:0] memword(input logic [63:0] a);
    if (hlt_on && a == 64'h10C)
      return 32'hD4400000;
    return a[31:0] + {gen, 24'h0};
  endfunction

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    logic        f;
    logic        p;
    logic [63:0] a;
    f = bus.imemReqValid & bus.imemReqReady;
    a = bus.imemReqAddr;
    p = instrValid & instrReady;
    if (p) begin
      got_pc.push_back(instrPC);
      got_w.push_back(instruction);
      got_cyc.push_back(cyc);
    end
    if (f) begin
      nreq++;
      req_log.push_back(a);
    end
    @(posedge clock);
    #1;
    cyc++;
    if (f) begin
      pend_a.push_back(a);
      pend_w.push_back(memword(a));
      pend_due.push_back(cyc + lat - 1);
    end
    bus.imemRspValid = 1'b0;
    bus.imemRspData  = '0;
    if (pend_due.size() > 0 && pend_due[0] <= cyc) begin
      bus.imemRspValid = 1'b1;
      bus.imemRspData  = pend_w[0];
      void'(pend_a.pop_front());
      void'(pend_w.pop_front());
      void'(pend_due.pop_front());
    end
  endtask

  task automatic run_until(input int n, input int budget);
    int k = 0;
    while (got_pc.size() < n && k < budget) begin
      step();
      k++;
    end
    check("deliveries", 64'(got_pc.size()), 64'(n));
  endtask

  task automatic clear_logs();
    got_pc.delete();
    got_w.delete();
    got_cyc.delete();
    req_log.delete();
    nreq = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    gen++;
    repeat (4) step();
    clear_logs();
    reset = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "time limit");
  end

  initial begin
    int n0;
    instrReady         = 1'b1;
    redirect           = 1'b0;
    redirectTarget     = '0;
    bus.imemReqReady   = 1'b1;
    bus.imemRspValid   = 1'b0;
    bus.imemRspData    = '0;

    reset = 1'b1;
    repeat (3) step();
    check("rst_iv",  64'(instrValid), 64'd0);
    check("rst_rv",  64'(bus.imemReqValid), 64'd0);
    check("rst_ins", 64'(instruction), 64'd0);
    check("rst_pc",  instrPC, 64'd0);
    check("rst_hlt", 64'(halted), 64'd0);
    reset = 1'b0;
    check("idle_rv", 64'(bus.imemReqValid), 64'd0);
    step();
    check("first_rv", 64'(bus.imemReqValid), 64'd1);
    check("first_addr", bus.imemReqAddr, 64'h100);
    run_until(3, 20);
    for (int i = 0; i < 3; i++) begin
      check("seq_pc", got_pc[i], 64'h100 + 64'(4*i));
      check("seq_w", 64'(got_w[i]),
            64'(memword(64'h100 + 64'(4*i))));
    end
    check("rate01", 64'(got_cyc[1] - got_cyc[0]), 64'd1);
    check("rate12", 64'(got_cyc[2] - got_cyc[1]), 64'd1);

    instrReady = 1'b0;
    do_reset();
    repeat (10) step();
    check("bp_nreq", 64'(nreq), 64'd4);
    check("bp_rv", 64'(bus.imemReqValid), 64'd0);
    check("bp_iv", 64'(instrValid), 64'd1);
    check("bp_pc", instrPC, 64'h100);
    check("bp_w", 64'(instruction), 64'(memword(64'h100)));
    repeat (3) step();
    check("bp_hold_pc", instrPC, 64'h100);
    check("bp_hold_n", 64'(nreq), 64'd4);
    instrReady = 1'b1;
    run_until(5, 30);
    for (int i = 0; i < 5; i++)
      check("bp_seq", got_pc[i], 64'h100 + 64'(4*i));
    check("bp_resume", req_log[4], 64'h110);

    lat = 3;
    do_reset();
    repeat (3) step();
    check("dr_nreq", 64'(nreq), 64'd2);
    bus.imemReqReady = 1'b0;
    redirect         = 1'b1;
    redirectTarget   = 64'h203;
    step();
    redirect         = 1'b0;
    bus.imemReqReady = 1'b1;
    check("dr_rv", 64'(bus.imemReqValid), 64'd0);
    check("dr_addr", bus.imemReqAddr, 64'h200);
    run_until(2, 30);
    check("dr_pc0", got_pc[0], 64'h200);
    check("dr_w0", 64'(got_w[0]), 64'(memword(64'h200)));
    check("dr_pc1", got_pc[1], 64'h204);
    check("dr_req", req_log[2], 64'h200);

    lat = 1;
    do_reset();
    repeat (4) step();
    check("rp_iv", 64'(instrValid), 64'd1);
    check("rp_pc", instrPC, 64'h104);
    check("rp_rv", 64'(bus.imemReqValid), 64'd1);
    redirect       = 1'b1;
    redirectTarget = 64'h300;
    step();
    redirect = 1'b0;
    check("rp_flush", 64'(instrValid), 64'd0);
    run_until(4, 30);
    check("rp_pc0", got_pc[0], 64'h100);
    check("rp_pc1", got_pc[1], 64'h104);
    check("rp_pc2", got_pc[2], 64'h300);
    check("rp_pc3", got_pc[3], 64'h304);
    check("rp_w2", 64'(got_w[2]), 64'(memword(64'h300)));

    hlt_on = 1'b1;
    do_reset();
`ifdef FETCH_HALT_EN
    run_until(4, 30);
    check("h_pc", got_pc[3], 64'h10C);
    check("h_w", 64'(got_w[3]), 64'hD4400000);
    check("h_halt", 64'(halted), 64'd1);
    check("h_iv", 64'(instrValid), 64'd0);
    check("h_rv", 64'(bus.imemReqValid), 64'd0);
    n0 = nreq;
    repeat (5) step();
    check("h_noreq", 64'(nreq), 64'(n0));
    redirect       = 1'b1;
    redirectTarget = 64'h500;
    step();
    redirect = 1'b0;
    repeat (3) step();
    check("h_redir", 64'(halted), 64'd1);
    check("h_redir_rv", 64'(bus.imemReqValid), 64'd0);
    check("h_redir_n", 64'(nreq), 64'(n0));
    check("h_nodel", 64'(got_pc.size()), 64'd4);
    reset = 1'b1;
    #1;
    check("h_clear", 64'(halted), 64'd0);
`else
    n0 = 0;
    run_until(5, 30);
    check("h_pass_w", 64'(got_w[3]), 64'hD4400000);
    check("h_pass_pc", got_pc[4], 64'h110);
    check("h_off", 64'(halted), 64'(n0));
`endif
    hlt_on = 1'b0;

    lat = 3;
    do_reset();
    repeat (5) step();
    check("mr_nreq", 64'(nreq), 64'd4);
    check("mr_iv", 64'(instrValid), 64'd1);
    check("mr_pc", instrPC, 64'h100);
    reset = 1'b1;
    gen++;
    #1;
    check("mr_iv0", 64'(instrValid), 64'd0);
    check("mr_ins0", 64'(instruction), 64'd0);
    check("mr_pc0", instrPC, 64'd0);
    check("mr_rv0", 64'(bus.imemReqValid), 64'd0);
    check("mr_h0", 64'(halted), 64'd0);
    repeat (4) step();
    clear_logs();
    reset = 1'b0;
    bus.imemRspValid = 1'b1;
    bus.imemRspData  = 32'hDEADBEEF;
    run_until(2, 30);
    check("mr_req0", req_log[0], 64'h100);
    check("mr_got0", got_pc[0], 64'h100);
    check("mr_w0", 64'(got_w[0]), 64'(memword(64'h100)));
    check("mr_got1", got_pc[1], 64'h104);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameter RESET_PC, default 64'h0: PC value loaded on reset.
REQ-002 Parameter FIFO_DEPTH, default 4 (power of two, 2..16): fetch buffer entries, which is also the in-flight request limit.
REQ-003 clock  input  1  main clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 imemReqValid  output  1  instruction-memory read request valid.
REQ-006 imemReqReady  input  1  instruction memory accepts the request.
REQ-007 imemReqAddr  output  64  request byte address; bits [1:0] always 0.
REQ-008 imemRspValid  input  1  response word valid; responses return in order, latency at least 1 cycle.
REQ-009 imemRspData  input  32  response instruction word.
REQ-010 instruction  output  32  instruction word to the decoder/controller.
REQ-011 instrPC  output  64  address of the instruction on `instruction`.
REQ-012 instrValid  output  1  `instruction` and `instrPC` are valid.
REQ-013 instrReady  input  1  decoder consumes the instruction.
REQ-014 redirect  input  1  taken branch (conditional or unconditional) resolved this cycle.
REQ-015 redirectTarget  input  64  branch target; bits [1:0] ignored (treated as 0).
REQ-016 halted  output  1  fetch stopped by HLT (see Configuration).

Function
REQ-017 Request handshake: a request transfers when imemReqValid and imemReqReady are both 1; after each transfer, fetchPC advances by 4.
REQ-018 While a request is stalled, imemReqValid and imemReqAddr hold stable until the transfer.
REQ-019 imemReqValid is 1 only in state FETCH and only while (buffered entries + in-flight requests) < FIFO_DEPTH.
REQ-020 Each accepted response is written into the FIFO as {PC, word}; the PC is taken from a request-order tag queue.
REQ-021 Output handshake: the FIFO head drives instruction/instrPC/instrValid; the head pops when instrValid and instrReady are both 1.
REQ-022 Output data holds stable while instrValid=1 and instrReady=0.
REQ-023 Latency: a response accepted in cycle N appears at the head no earlier than cycle N+1, and at N+1 when the FIFO is empty.
REQ-024 FIFO pointers wrap modulo FIFO_DEPTH; full/empty are distinguished by an extra pointer bit.
REQ-025 The FIFO never overflows; a response arriving when no request is outstanding is ignored.
REQ-026 States: IDLE, FETCH, DRAIN, HALT.
REQ-027 IDLE -> FETCH: one cycle after reset deasserts.
REQ-028 FETCH -> DRAIN: on redirect while in-flight requests > 0.
REQ-029 FETCH -> FETCH: on redirect with 0 in-flight requests.
REQ-030 DRAIN -> FETCH: when the discard count reaches 0.
REQ-031 On redirect: in the same edge, flush the FIFO, set fetchPC to {redirectTarget[63:2],2'b00}, set the discard count to the in-flight count, and drive instrValid to 0 the next cycle.
REQ-032 Redirect in the same cycle as a request transfer: that request is counted as in flight and its response is discarded.
REQ-033 Redirect in the same cycle as an output pop: the pop completes; the remaining entries are flushed.
REQ-034 Redirect in the same cycle as a response: that response is discarded.
REQ-035 In DRAIN, no requests are issued and each response decrements the discard count without a FIFO write.
REQ-036 A redirect while in DRAIN reloads fetchPC, adds any newly in-flight requests to the discard count, and stays in DRAIN.

Reset
REQ-037 Reset asynchronously forces: state IDLE, fetchPC=RESET_PC, FIFO and tag pointers 0, in-flight and discard counts 0.
REQ-038 Reset asynchronously forces: imemReqValid=0, instrValid=0, instruction=0, instrPC=0, halted=0.
REQ-039 Reset mid-transaction abandons all in-flight responses; responses arriving during or after reset with no outstanding request are ignored per REQ-025.

Configuration
REQ-040 Macro FETCH_HALT_EN, when defined: a pop of instruction 32'hD4400000 (HLT) moves the block to HALT.
REQ-041 HALT behaviour: imemReqValid=0, instrValid=0, halted=1, responses discarded; only reset exits HALT, and redirect is ignored.
REQ-042 When FETCH_HALT_EN is undefined: the HALT state is absent, halted is tied to 0, and HLT passes through as an ordinary word.

Verification
REQ-043 Reset with RESET_PC=0x100, ready=1, latency 1, instrReady=1 -> instrPC sequence 0x100, 0x104, 0x108, one per cycle, with words matching memory.
REQ-044 instrReady=0 for 10 cycles, FIFO_DEPTH=4 -> exactly 4 requests issued, then imemReqValid=0; the head stays stable; releasing instrReady resumes requests.
REQ-045 Latency 3, 2 requests in flight, redirect to 0x203 -> next request address 0x200; the 2 stale responses are dropped; the first delivered instrPC is 0x200.
REQ-046 Redirect in the same cycle as a pop of the 0x104 instruction and a request transfer -> 0x104 is consumed once; no stale word reaches the output.
REQ-047 With FETCH_HALT_EN, HLT at 0x10C -> halted=1 after its pop; no further requests; a redirect has no effect; reset clears the halt.
REQ-048 Reset asserted mid-burst with 3 in flight -> all outputs 0 immediately; after release, fetch restarts at RESET_PC with no stale deliveries.
